// File: rtl/ifetch.sv
// Instruction fetch front end: requests one instruction word at a time from
// instruction memory, holds it for the decoder until it is accepted, and
// follows redirects from taken branches and jumps.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// FETCH   | request outstanding at fa; on ack the word is captured
// HOLD    | instruction presented to decode, waiting for instr_ready
// DISCARD | redirected while a request was in flight; drop the response
module ifetch #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  // instruction memory
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  // redirect from execute
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  // decode side
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic [PC_W-1:0]    pcplus1,
  output logic               instr_valid,
  input  logic               instr_ready
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    fa_q, fa_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcplus1_q, pcplus1_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    fa_inc;

  // Increment wraps naturally at 2^PC_W.
  assign fa_inc = fa_q + PC_W'(1);

  // Next-state and datapath updates; redirect is tested first in every state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fa_d      = fa_q;
    instr_d   = instr_q;
    pcplus1_d = pcplus1_q;
    valid_d   = valid_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          if (imem_ack) begin
            // Response dropped; restart the request at the target.
            fa_d = redirect_pc;
          end else begin
            // Request must stay stable until its ack, so wait it out.
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          instr_d   = imem_rdata;
          pcplus1_d = fa_inc;
          pc_d      = fa_inc;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          fa_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (instr_ready) begin
          fa_d    = pc_q;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        valid_d = 1'b0;
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          fa_d    = redirect ? redirect_pc : pc_q;
          state_d = FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        fa_d    = pc_q;
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      fa_q      <= '0;
      instr_q   <= '0;
      pcplus1_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fa_q      <= fa_d;
      instr_q   <= instr_d;
      pcplus1_q <= pcplus1_d;
      valid_q   <= valid_d;
    end
  end

  // Request and valid are gated by reset so they drop in the reset cycle itself.
  assign imem_req    = ~reset & (state_q != HOLD);
  assign imem_addr   = fa_q;
  assign instr       = instr_q;
  assign op          = instr_q[INSTR_W-1:INSTR_W-4];
  assign pcplus1     = pcplus1_q;
  assign instr_valid = valid_q & ~reset;

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a memory responder with random wait states,
// random decode back-pressure, redirects and resets, checked against a
// transaction-level model of the expected instruction stream.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [15:0] instr;
  logic [3:0]  op;
  logic [7:0]  pcplus1;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  ifetch #(.PC_W(8), .INSTR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .op          (op),
    .pcplus1     (pcplus1),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] mem [256];

  initial begin
    logic [7:0]  exp_pc, exp_pc1;
    logic [15:0] exp_word;
    bit          new_req, discard, exp_cap;
    int          wait_cnt, delivered, sel;
    logic        p_reset, p_req, p_ack, p_redirect, p_ready, p_valid;
    logic [7:0]  p_rpc, p_addr;
    logic [15:0] p_instr;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h4123;

    exp_pc = '0; new_req = 1'b1; discard = 1'b0; wait_cnt = 0; delivered = 0;
    p_reset = 1'b1; p_req = 1'b0; p_ack = 1'b0; p_redirect = 1'b0; p_ready = 1'b0;
    p_valid = 1'b0; p_rpc = '0; p_addr = '0; p_instr = '0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      // Advance the reference model by the edge that just happened.
      exp_cap = 1'b0;
      if (p_reset) begin
        exp_pc   = '0;
        new_req  = 1'b1;
        discard  = 1'b0;
        wait_cnt = (cyc < 40) ? 0 : int'($urandom_range(0, 3));
      end else begin
        if (p_req && p_ack) begin
          exp_cap  = !p_redirect && !discard;
          discard  = 1'b0;
          new_req  = 1'b1;
          wait_cnt = int'($urandom_range(0, 3));
        end
        if (p_redirect) begin
          exp_pc = p_rpc;
          if (p_req && !p_ack) discard = 1'b1;
          if (p_valid) new_req = 1'b1;
        end else if (p_valid && p_ready) begin
          exp_pc = exp_pc + 8'd1;
          new_req = 1'b1;
          delivered++;
        end
      end

      // Drive this cycle's stimulus.
      reset = (cyc < 3) || ($urandom_range(0, 199) == 0);
      redirect = (cyc > 40) && ($urandom_range(0, 19) == 0);
      sel = int'($urandom_range(0, 7));
      redirect_pc = (sel < 2) ? 8'hFE : (sel == 2) ? 8'hFF : (sel == 3) ? 8'h40 : 8'($urandom);
      if ((cyc % 512) < 256) instr_ready = ($urandom_range(0, 3) != 0);
      else                   instr_ready = ($urandom_range(0, 5) == 0);
      #1;
      if (imem_req) begin
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'($urandom);
          wait_cnt--;
        end
      end else begin
        // Stray acks while idle must be ignored.
        imem_ack   = ($urandom_range(0, 7) == 0);
        imem_rdata = 16'($urandom);
      end
      #1;

      if (reset) begin
        chk("req_in_reset", 32'(imem_req), 32'd0);
        chk("valid_in_reset", 32'(instr_valid), 32'd0);
        if (p_reset) begin
          chk("instr_reset", 32'(instr), 32'd0);
          chk("pcplus1_reset", 32'(pcplus1), 32'd0);
          chk("addr_reset", 32'(imem_addr), 32'd0);
        end
      end else begin
        chk("req_xor_valid", 32'(imem_req ^ instr_valid), 32'd1);
        if (p_reset) chk("req_after_reset", 32'(imem_req), 32'd1);
        if (!p_reset && p_req && !p_ack) begin
          chk("req_stable", 32'(imem_req), 32'd1);
          chk("addr_stable", 32'(imem_addr), 32'(p_addr));
        end
        if (exp_cap) chk("capture_valid", 32'(instr_valid), 32'd1);
        if (!p_reset && p_valid && !p_ready && !p_redirect) begin
          chk("hold_valid", 32'(instr_valid), 32'd1);
          chk("hold_instr", 32'(instr), 32'(p_instr));
        end
        if (!p_reset && p_valid && (p_ready || p_redirect))
          chk("valid_drop", 32'(instr_valid), 32'd0);
        if (imem_req && new_req) begin
          chk("req_addr", 32'(imem_addr), 32'(exp_pc));
          new_req = 1'b0;
        end
        if (instr_valid) begin
          exp_word = mem[exp_pc];
          exp_pc1  = exp_pc + 8'd1;
          chk("instr", 32'(instr), 32'(exp_word));
          chk("op", 32'(op), 32'(exp_word[15:12]));
          chk("pcplus1", 32'(pcplus1), 32'(exp_pc1));
        end
      end

      p_reset = reset; p_req = imem_req; p_ack = imem_ack; p_redirect = redirect;
      p_ready = instr_ready; p_valid = instr_valid; p_rpc = redirect_pc;
      p_addr = imem_addr; p_instr = instr;
    end

    chk("progress", 32'(delivered > 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
